// File: rtl/timer_sched.sv
// Round-robin programming sequencer for a three-channel timer slave, with
// bus-timeout handling and sticky per-channel interrupts from the timer OUT lines.
module timer_sched #(
    parameter int TO_CYC = 15
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [2:0]  REQ_I,
    input  logic [5:0]  REQ_MODE_I,
    input  logic [95:0] REQ_CNT_I,
    output logic [2:0]  GNT_O,
    output logic [2:0]  ERR_O,
    output logic        BUSY_O,
    output logic [3:0]  ADR_O,
    output logic [31:0] DAT_O,
    output logic        WE_O,
    output logic        STB_O,
    input  logic        ACK_I,
    input  logic [2:0]  TOUT_I,
    input  logic [2:0]  IRQ_CLR_I,
    output logic [2:0]  IRQ_O
);
    localparam int CW = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {IDLE, WR_CTL0, WR_CNT, WR_CTL1, DONE} state_t;

    state_t         state, state_nxt;
    logic [1:0]     ch, rr_ptr, win, win_mode, mode;
    logic           win_vld, write_st, timeout, arb_go;
    logic [2:0]     ch_oh, win_oh, err_q, tout_q, irq, prog_mask;
    logic [31:0]    cnt;
    logic [3:0]     adr_base;
    logic [CW-1:0]  wait_cnt;

    // Search starts at the channel after the last one served.
    always_comb begin
        logic [2:0] idx;
        idx     = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idx = {1'b0, rr_ptr} + 3'(i) + 3'd1;
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (REQ_I[idx[1:0]] && !win_vld) begin
                win     = idx[1:0];
                win_vld = 1'b1;
            end
        end
    end

    assign win_mode = REQ_MODE_I[2*win +: 2];
    assign win_oh   = 3'b001 << win;
    assign ch_oh    = 3'b001 << ch;
    // Arbitration pauses during an ERR pulse: the requester still holds REQ_I that cycle.
    assign arb_go   = (state == IDLE) && win_vld && (err_q == 3'b000);
    assign write_st = (state == WR_CTL0) || (state == WR_CNT) || (state == WR_CTL1);
    assign timeout  = write_st && !ACK_I && (wait_cnt == CW'(TO_CYC - 1));
    assign adr_base = {2'b00, ch} + {1'b0, ch, 1'b0};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_go && win_mode != 2'b11) state_nxt = WR_CTL0;
            WR_CTL0: if (ACK_I) state_nxt = WR_CNT;  else if (timeout) state_nxt = IDLE;
            WR_CNT:  if (ACK_I) state_nxt = WR_CTL1; else if (timeout) state_nxt = IDLE;
            WR_CTL1: if (ACK_I) state_nxt = DONE;    else if (timeout) state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ADR_O = '0;
        DAT_O = '0;
        case (state)
            WR_CTL0: ADR_O = adr_base;
            WR_CNT:  begin ADR_O = adr_base + 4'd1; DAT_O = cnt; end
            WR_CTL1: begin ADR_O = adr_base; DAT_O = {29'b0, mode, 1'b1}; end
            default: ;
        endcase
    end

    assign STB_O  = write_st;
    assign WE_O   = write_st;
    assign BUSY_O = (state != IDLE);
    assign GNT_O  = (state == DONE) ? ch_oh : 3'b000;
    assign ERR_O  = err_q;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state    <= IDLE;
            ch       <= 2'd0;
            rr_ptr   <= 2'd2;
            mode     <= 2'd0;
            cnt      <= '0;
            wait_cnt <= '0;
            err_q    <= '0;
        end else begin
            state <= state_nxt;
            err_q <= '0;
            if (arb_go) begin
                ch   <= win;
                mode <= win_mode;
                cnt  <= REQ_CNT_I[32*win +: 32];
                if (win_mode == 2'b11) begin
                    err_q  <= win_oh;
                    rr_ptr <= win;
                end
            end
            if (timeout) begin
                err_q  <= ch_oh;
                rr_ptr <= ch;
            end
            if (state == DONE) rr_ptr <= ch;
            if (state_nxt != state) wait_cnt <= '0;
            else if (write_st)      wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A channel's own OUT line glitches while it is reprogrammed; ignore those edges.
    assign prog_mask = (state != IDLE) ? ch_oh : 3'b000;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            tout_q <= 3'b111;
            irq    <= '0;
        end else begin
            tout_q <= TOUT_I;
            irq    <= (irq & ~IRQ_CLR_I) | (TOUT_I & ~tout_q & ~prog_mask);
        end
    end

    assign IRQ_O = irq;
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: drives and samples on the falling edge,
// slave ACK is combinational from STB_O unless stalled.
module tb_timer_sched;
    logic        CLK_I, RST_I;
    logic [2:0]  REQ_I;
    logic [5:0]  REQ_MODE_I;
    logic [95:0] REQ_CNT_I;
    logic [2:0]  GNT_O, ERR_O;
    logic        BUSY_O;
    logic [3:0]  ADR_O;
    logic [31:0] DAT_O;
    logic        WE_O, STB_O, ACK_I;
    logic [2:0]  TOUT_I, IRQ_CLR_I, IRQ_O;
    logic        ack_en;

    int total = 0;
    int bad   = 0;

    timer_sched #(.TO_CYC(15)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .REQ_I(REQ_I), .REQ_MODE_I(REQ_MODE_I),
        .REQ_CNT_I(REQ_CNT_I), .GNT_O(GNT_O), .ERR_O(ERR_O), .BUSY_O(BUSY_O),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .WE_O(WE_O), .STB_O(STB_O), .ACK_I(ACK_I),
        .TOUT_I(TOUT_I), .IRQ_CLR_I(IRQ_CLR_I), .IRQ_O(IRQ_O)
    );

    assign ACK_I = STB_O & ack_en;

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK_I);
    endtask

    // Bounded wait for a grant; also reports any error pulse seen meanwhile.
    task automatic wait_gnt(output logic [2:0] g, output logic [2:0] e);
        g = '0;
        e = '0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            e = e | ERR_O;
            if (GNT_O != 3'b000) begin
                g = GNT_O;
                break;
            end
        end
    endtask

    initial begin
        logic [2:0] g, e;
        int n;
        RST_I = 1'b1; REQ_I = '0; REQ_MODE_I = 6'b010101; REQ_CNT_I = '0;
        TOUT_I = 3'b111; IRQ_CLR_I = '0; ack_en = 1'b1;
        cyc(); cyc();
        chk("rst_busy", BUSY_O, 0);
        chk("rst_stb", {WE_O, STB_O}, 0);
        chk("rst_bus", {ADR_O, DAT_O}, 0);
        chk("rst_gnt_err", {GNT_O, ERR_O}, 0);
        chk("rst_irq", IRQ_O, 0);
        RST_I = 1'b0;
        cyc(); cyc();
        chk("tout_high_no_irq", IRQ_O, 0);

        // single zero-wait programming of channel 0
        REQ_I = 3'b001; REQ_MODE_I = 6'b010101; REQ_CNT_I[31:0] = 32'd100;
        cyc();
        chk("w0_stb_we", {STB_O, WE_O}, 2'b11);
        chk("w0_adr", ADR_O, 0);
        chk("w0_dat", DAT_O, 0);
        REQ_CNT_I[31:0] = 32'd555; REQ_MODE_I = 6'b101010;
        cyc();
        chk("w1_adr", ADR_O, 1);
        chk("w1_dat", DAT_O, 100);
        cyc();
        chk("w2_adr", ADR_O, 0);
        chk("w2_dat", DAT_O, 3);
        cyc();
        chk("done_gnt", GNT_O, 3'b001);
        chk("done_stb", STB_O, 0);
        chk("done_busy", BUSY_O, 1);
        REQ_I = '0; REQ_MODE_I = 6'b010101;
        cyc();
        chk("idle_busy", BUSY_O, 0);
        chk("idle_gnt", GNT_O, 0);

        // round-robin from reset pointer
        RST_I = 1'b1; cyc(); RST_I = 1'b0;
        REQ_I = 3'b111;
        wait_gnt(g, e); chk("rr_first", g, 3'b001); REQ_I[0] = 1'b0;
        wait_gnt(g, e); chk("rr_second", g, 3'b010); REQ_I[1] = 1'b0;
        wait_gnt(g, e); chk("rr_third", g, 3'b100); REQ_I[2] = 1'b0;
        cyc();
        REQ_I = 3'b101;
        wait_gnt(g, e); chk("rr_re0", g, 3'b001); REQ_I[0] = 1'b0;
        wait_gnt(g, e); chk("rr_re2", g, 3'b100); REQ_I[2] = 1'b0;
        chk("rr_no_err", e, 0);
        cyc();

        // reserved mode rejected without bus traffic
        REQ_I = 3'b010; REQ_MODE_I = 6'b011101;
        cyc();
        chk("mode3_err", ERR_O, 3'b010);
        chk("mode3_stb", STB_O, 0);
        chk("mode3_busy", BUSY_O, 0);
        REQ_I = '0; REQ_MODE_I = 6'b010101;
        cyc();
        chk("mode3_err_once", ERR_O, 0);
        chk("mode3_stb2", STB_O, 0);

        // bus timeout with ACK stalled
        ack_en = 1'b0; REQ_I = 3'b001; n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (STB_O) n++;
            else if (n > 0) break;
        end
        chk("to_stb_cycles", n, 15);
        chk("to_err", ERR_O, 3'b001);
        chk("to_busy", BUSY_O, 0);
        REQ_I = '0; ack_en = 1'b1;
        cyc();
        chk("to_err_once", ERR_O, 0);

        // sticky interrupt, set beats clear
        TOUT_I = 3'b011; cyc();
        chk("irq_fall", IRQ_O, 0);
        TOUT_I = 3'b111; cyc();
        chk("irq_rise", IRQ_O, 3'b100);
        IRQ_CLR_I = 3'b100; TOUT_I = 3'b011; cyc();
        chk("irq_clr", IRQ_O, 0);
        TOUT_I = 3'b111; cyc();
        chk("irq_set_wins", IRQ_O, 3'b100);
        IRQ_CLR_I = 3'b000; cyc();
        chk("irq_sticky", IRQ_O, 3'b100);
        IRQ_CLR_I = 3'b100; cyc();
        chk("irq_clr2", IRQ_O, 0);
        IRQ_CLR_I = 3'b000;

        // OUT edge on the channel being programmed is masked
        TOUT_I = 3'b110; cyc();
        REQ_I = 3'b001; cyc(); cyc();
        chk("mask_in_wrcnt", ADR_O, 1);
        TOUT_I = 3'b111; cyc();
        chk("mask_irq", IRQ_O, 0);
        cyc();
        chk("mask_gnt", GNT_O, 3'b001);
        REQ_I = '0; cyc();
        chk("mask_irq_after", IRQ_O, 0);

        // reset in the middle of a sequence
        REQ_I = 3'b001; cyc(); cyc();
        chk("mid_wrcnt", {STB_O, ADR_O}, 5'b10001);
        RST_I = 1'b1; #1;
        chk("mid_rst_stb", STB_O, 0);
        chk("mid_rst_busy", BUSY_O, 0);
        chk("mid_rst_gnt_err", {GNT_O, ERR_O}, 0);
        cyc();
        chk("mid_rst_hold", {BUSY_O, GNT_O, ERR_O}, 0);
        RST_I = 1'b0;
        wait_gnt(g, e);
        chk("post_rst_gnt", g, 3'b001);
        chk("post_rst_no_err", e, 0);
        REQ_I = '0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
